// File: rtl/spi_mem_writer.sv
// SPI-slave (mode 0, MSB first) that streams N-bit words into an M-word config memory.
// Optional readback of the shift register on miso when SPI_READBACK_EN is defined.
module spi_mem_writer #(
  parameter  int M  = 10,
  parameter  int N  = 8,
  localparam int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          load_done,
  output logic          overflow
);

  localparam int BW  = $clog2(N);
  localparam int WCW = $clog2(M + 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(N - 1);
  localparam logic [WCW-1:0] WC_FULL   = WCW'(M);
  localparam logic [WCW-1:0] WC_LAST   = WCW'(M - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_sclk_q, r_cs_q, r_mosi_q;
  logic            r_sclk_prev, r_cs_prev;
  logic [BW-1:0]   r_bcnt;
  logic [WCW-1:0]  r_wcnt;
  logic [N-1:0]    r_shreg;
  logic [AW-1:0]   r_mem_addr;
  logic [N-1:0]    r_mem_data;
  logic            r_mem_we, r_load_done, r_overflow;

  logic            w_sclk_s, w_cs_s, w_mosi_s;
  logic            w_sclk_rise, w_cs_fall;
  logic [N-1:0]    w_shreg_nxt;
  state_t          w_exit_state;

  assign w_sclk_s     = r_sclk_q[1];
  assign w_cs_s       = r_cs_q[1];
  assign w_mosi_s     = r_mosi_q[1];
  assign w_sclk_rise  = w_sclk_s & ~r_sclk_prev;
  assign w_cs_fall    = r_cs_prev & ~w_cs_s;
  assign w_shreg_nxt  = {r_shreg[N-2:0], w_mosi_s};
  assign w_exit_state = r_load_done ? DONE : IDLE;

  // cs_n synchroniser resets to the deselected level so busy reads 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_q    <= 2'b00;
      r_cs_q      <= 2'b11;
      r_mosi_q    <= 2'b00;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_q    <= {r_sclk_q[0], sclk};
      r_cs_q      <= {r_cs_q[0], cs_n};
      r_mosi_q    <= {r_mosi_q[0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_shreg     <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_cs_fall) begin
            r_state     <= SHIFT;
            r_bcnt      <= '0;
            r_wcnt      <= '0;
            r_load_done <= 1'b0;
            r_overflow  <= 1'b0;
          end
        end
        SHIFT: begin
          // A completed word wins over a simultaneous deselect.
          if (w_sclk_rise && r_bcnt == LAST_BIT) begin
            r_shreg <= w_shreg_nxt;
            r_bcnt  <= '0;
            r_state <= WRITE;
            if (r_wcnt < WC_FULL) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_wcnt[AW-1:0];
              r_mem_data <= w_shreg_nxt;
            end
          end else if (w_cs_s) begin
            r_bcnt  <= '0;
            r_state <= w_exit_state;
          end else if (w_sclk_rise) begin
            r_shreg <= w_shreg_nxt;
            r_bcnt  <= r_bcnt + 1'b1;
          end
        end
        WRITE: begin
          if (r_wcnt == WC_FULL) r_overflow <= 1'b1;
          else                   r_wcnt     <= r_wcnt + 1'b1;
          if (r_wcnt == WC_LAST) r_load_done <= 1'b1;
          if (w_cs_s) r_state <= (r_load_done || r_wcnt == WC_LAST) ? DONE : IDLE;
          else        r_state <= SHIFT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_we    = r_mem_we;
  assign busy      = ~w_cs_s;
  assign load_done = r_load_done;
  assign overflow  = r_overflow;

`ifdef SPI_READBACK_EN
  logic r_miso;
  logic w_sclk_fall;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;

  // Launch on the falling edge so the host samples a stable bit on the next rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_miso <= 1'b0;
    else if (w_cs_s)      r_miso <= 1'b0;
    else if (w_sclk_fall) r_miso <= r_shreg[N-1];
  end
  assign miso = r_miso;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_writer.sv
// Self-checking bench for spi_mem_writer: scoreboard of expected memory writes plus frame-level flag checks.
module tb_spi_mem_writer;
  localparam int M  = 10;
  localparam int N  = 8;
  localparam int AW = $clog2(M);

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [AW-1:0] a; logic [N-1:0] d; } wr_t;

  logic clk = 1'b0;
  logic reset, sclk, cs_n, mosi;
  logic miso, mem_we, busy, load_done, overflow;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_data;

  int tests = 0;
  int fails = 0;
  wr_t exp_q[$];
  logic [N-1:0] dut_mem [M];

  spi_mem_writer #(.M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .load_done(load_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write the DUT makes must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.a);
        check("wr_data", mem_data, e.d);
      end
      if (mem_addr < M) dut_mem[mem_addr] = mem_data;
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, input int half);
    sclk = 1'b0;
    mosi = b;
    wait_clk(half);
    sclk = 1'b1;
    wait_clk(half);
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nb, input int half);
    for (int i = 0; i < nb; i++) spi_bit(v[7-i], half);
  endtask

  task automatic open_frame();
    cs_n = 1'b0;
    wait_clk(6);
    check("busy_in_frame", busy, 1);
  endtask

  // Model: words are written in order from address 0 until the memory is full.
  task automatic expect_words(input bq_t w);
    for (int i = 0; i < w.size(); i++)
      if (i < M) exp_q.push_back({AW'(i), w[i]});
  endtask

  task automatic close_frame(input bq_t w, input int half);
    int nw;
    nw = w.size();
    sclk = 1'b0;
    wait_clk(half + 4);
    cs_n = 1'b1;
    wait_clk(8);
    check("pending_writes", exp_q.size(), 0);
    check("busy_after", busy, 0);
    check("load_done", load_done, (nw >= M) ? 1 : 0);
    check("overflow", overflow, (nw > M) ? 1 : 0);
    check("miso_idle", miso, 0);
    if (nw > 0) begin
      check("addr_hold", mem_addr, ((nw < M) ? nw : M) - 1);
      check("addr0_kept", dut_mem[0], w[0]);
    end
  endtask

  task automatic run_frame(input bq_t w, input int npart, input int half);
    logic [7:0] pbits;
    expect_words(w);
    open_frame();
    foreach (w[i]) spi_bits(w[i], N, half);
    pbits = 8'($urandom);
    spi_bits(pbits, npart, half);
    close_frame(w, half);
  endtask

  initial begin
    bq_t w;
    logic [7:0] rb;
    logic exp_miso;
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wait_clk(4);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_miso", miso, 0);
    reset = 1'b0;
    wait_clk(4);

    // Full frame of exactly M words
    w = {};
    for (int i = 1; i <= M; i++) w.push_back(8'(i));
    run_frame(w, 0, 2);

    // Reset mid-frame clears everything, including sticky flags and held address
    cs_n = 1'b0;
    wait_clk(6);
    spi_bits(8'hC3, 3, 2);
    reset = 1'b1;
    #2;
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data", mem_data, 0);
    check("mid_rst_load_done", load_done, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_busy", busy, 0);
    cs_n = 1'b1; sclk = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(8);

    // Overflow frame: M+1 words, no wrap to address 0
    w = {8'h5A};
    for (int i = 1; i <= M; i++) w.push_back(8'($urandom));
    run_frame(w, 0, 2);

    // Two words plus a partial word, then the next frame must restart at 0
    w = {8'hA5, 8'h3C};
    run_frame(w, 5, 2);
    w = {8'h77};
    run_frame(w, 0, 2);

    // Random frames at sclk = clk/4
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, M + 2);
      w = {};
      for (int i = 0; i < n; i++) w.push_back(8'($urandom));
      run_frame(w, $urandom_range(0, N - 1), 2);
    end

    // Readback: previous word appears on miso during the following word
    w = {8'hA5, 8'h00};
    rb = 8'hA5;
    expect_words(w);
    open_frame();
    spi_bits(8'hA5, N, 8);
    for (int i = 0; i < N; i++) begin
      sclk = 1'b0;
      mosi = 1'b0;
      wait_clk(8);
`ifdef SPI_READBACK_EN
      exp_miso = rb[7-i];
`else
      exp_miso = 1'b0;
`endif
      check("miso_readback", miso, exp_miso);
      sclk = 1'b1;
      wait_clk(8);
    end
    close_frame(w, 8);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
